// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_prefetch_unit_pkg;

    localparam int unsigned FETCH_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_REQ   = 2'd1,
        FETCH_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Circular-buffer FIFO with a separate occupancy count and a synchronous flush.
// The head outputs read as zero whenever the buffer is empty.
module sync_fifo
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push    = push && (count != CW'(DEPTH));
    assign do_pop     = pop && (count != '0);
    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write port; contents need no reset because count gates the head.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues one sequential word read at a time,
// buffers {pc, instr} pairs in a FIFO and supports redirect flushes.
module fetch_prefetch_unit
    import fetch_prefetch_unit_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'('h1000)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [XLEN-1:0]          mem_rdata,
    input  logic                     mem_resp,
    output logic [XLEN-1:0]          mem_addr,
    output logic                     mem_read,
    input  logic                     redirect,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     instr_valid,
    output logic [XLEN-1:0]          instr_data,
    output logic [XLEN-1:0]          instr_pc,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   fetch_pc_nxt;
    logic [XLEN-1:0]   req_addr;
    logic              issue;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] head_data;

    // A redirect kills any pop in its cycle.
    assign pop      = instr_valid && instr_ready && !redirect;
    assign mem_read = (state != FETCH_IDLE);
    assign mem_addr = req_addr;
    assign instr_pc   = head_data[2*XLEN-1:XLEN];
    assign instr_data = head_data[XLEN-1:0];

    // Next-state, push and issue decisions; redirect overrides fetch_pc last.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        issue        = 1'b0;
        push         = 1'b0;
        case (state)
            FETCH_IDLE: begin
                // A same-cycle pop frees a slot, so a full FIFO may still issue.
                if (!redirect && ((fifo_count != CW'(DEPTH)) || pop)) begin
                    issue     = 1'b1;
                    state_nxt = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (redirect) begin
                    state_nxt = mem_resp ? FETCH_IDLE : FETCH_DRAIN;
                end else if (mem_resp) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + XLEN'(FETCH_WORD_BYTES);
                    state_nxt    = FETCH_IDLE;
                end
            end
            FETCH_DRAIN: begin
                if (mem_resp) state_nxt = FETCH_IDLE;
            end
            default: state_nxt = FETCH_IDLE;
        endcase
        if (redirect) fetch_pc_nxt = {redirect_pc[XLEN-1:2], 2'b00};
    end

    // State, fetch PC and latched request address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            if (issue) req_addr <= fetch_pc;
        end
    end

    sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_data  ({fetch_pc, mem_rdata}),
        .pop        (pop),
        .head_valid (instr_valid),
        .head_data  (head_data),
        .count      (fifo_count)
    );

endmodule
